iob_eth_tx_gen: RTL and testbench



---
 rtl/iob_eth_tx_gen.sv | 199 +++++++++++++++++++
 tb/tb_iob_eth_tx_gen.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_tx_gen.sv
// MII/GMII frame transmitter: preamble/SFD, payload from buffer,
// optional zero padding and CRC-32 FCS, IFG timing and abort.
module iob_eth_tx_gen #(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 11,
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic              tx_clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [7:0]        data_i,
  input  logic              send_i,
  input  logic [ADDR_W-1:0] nbytes_i,
  input  logic              crc_en_i,
  input  logic              pad_en_i,
  input  logic              abort_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              tx_en_o,
  output logic              tx_er_o,
  output logic [DATA_W-1:0] tx_data_o
);

  localparam int SPB = 8 / DATA_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_SFD   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_PAD   = 3'd4;
  localparam logic [2:0] S_FCS   = 3'd5;
  localparam logic [2:0] S_ABORT = 3'd6;
  localparam logic [2:0] S_IFG   = 3'd7;

  localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PREAMBLE_LEN - 1);
  localparam logic [ADDR_W-1:0] IFG_LAST = ADDR_W'(IFG_BYTES - 1);
  localparam logic [ADDR_W-1:0] FCS_LAST = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] MIN_LEN  = ADDR_W'(MIN_FRAME);
  localparam logic [31:0]       POLY     = 32'hEDB88320;

  logic [2:0]        r_state;
  logic              r_sym;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_end;
  logic              r_crc_en;
  logic              r_aborted;
  logic [7:0]        r_byte;
  logic [31:0]       r_crc;

  logic              w_last_sym;
  logic              w_first_sym;
  logic              w_tx_on;
  logic [ADDR_W-1:0] w_cnt_inc;
  logic [ADDR_W-1:0] w_end;
  logic [2:0]        w_post_pad;
  logic [2:0]        w_post_data;
  logic [7:0]        w_cur_byte;

  function automatic logic [31:0] f_crc8(input logic [31:0] c,
                                         input logic [7:0]  b);
    logic [31:0] v;
    v = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    return v;
  endfunction

  assign w_last_sym  = (SPB == 1) ? 1'b1 : r_sym;
  assign w_first_sym = ~r_sym;
  assign w_cnt_inc   = r_cnt + ADDR_W'(1);
  assign w_tx_on     = r_state inside {S_PRE, S_SFD, S_DATA,
                                       S_PAD, S_FCS, S_ABORT};
  assign w_end       = (pad_en_i && nbytes_i < MIN_LEN) ? MIN_LEN
                                                        : nbytes_i;
  assign w_post_pad  = r_crc_en ? S_FCS : S_IFG;
  assign w_post_data = (r_end != r_len) ? S_PAD : w_post_pad;

  // Byte k+1 is addressed during the last symbol of byte k.
  assign addr_o = (r_state == S_DATA && w_last_sym && w_cnt_inc != r_len)
                ? w_cnt_inc : '0;

  assign ready_o = (r_state == S_IDLE);
  assign tx_en_o = w_tx_on;
  assign tx_er_o = (r_state == S_ABORT);
  assign done_o  = (r_state == S_IFG) && w_last_sym &&
                   (r_cnt == IFG_LAST) && !r_aborted;

  always_comb begin
    w_cur_byte = 8'h00;
    unique case (r_state)
      S_PRE:   w_cur_byte = 8'h55;
      S_SFD:   w_cur_byte = 8'hD5;
      S_DATA:  w_cur_byte = w_first_sym ? data_i : r_byte;
      S_FCS:   w_cur_byte = ~r_crc[7:0];
      default: w_cur_byte = 8'h00;
    endcase
  end

  if (DATA_W == 8) begin : g_gmii
    assign tx_data_o = w_cur_byte;
  end else begin : g_mii
    assign tx_data_o = r_sym ? w_cur_byte[7:4] : w_cur_byte[3:0];
  end

  always_ff @(posedge tx_clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_sym     <= 1'b0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_end     <= '0;
      r_crc_en  <= 1'b0;
      r_aborted <= 1'b0;
      r_byte    <= '0;
      r_crc     <= '1;
    end else if (w_tx_on && abort_i && r_state != S_ABORT) begin
      r_state   <= S_ABORT;
      r_sym     <= 1'b0;
      r_cnt     <= '0;
      r_aborted <= 1'b1;
    end else begin
      if (r_state != S_IDLE)
        r_sym <= w_last_sym ? 1'b0 : ~r_sym;
      unique case (r_state)
        S_IDLE: if (send_i) begin
          r_len     <= nbytes_i;
          r_end     <= w_end;
          r_crc_en  <= crc_en_i;
          r_aborted <= 1'b0;
          r_crc     <= '1;
          r_cnt     <= '0;
          r_state   <= S_PRE;
        end
        S_PRE: if (w_last_sym) begin
          if (r_cnt == PRE_LAST) begin
            r_cnt   <= '0;
            r_state <= S_SFD;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_SFD: if (w_last_sym)
          r_state <= (r_len != '0) ? S_DATA : w_post_data;
        S_DATA: begin
          if (w_first_sym) begin
            r_byte <= data_i;
            r_crc  <= f_crc8(r_crc, data_i);
          end
          if (w_last_sym) begin
            if (w_cnt_inc == r_len) begin
              r_state <= w_post_data;
              r_cnt   <= (r_end != r_len) ? w_cnt_inc : '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_PAD: begin
          if (w_first_sym)
            r_crc <= f_crc8(r_crc, 8'h00);
          if (w_last_sym) begin
            if (w_cnt_inc == r_end) begin
              r_state <= w_post_pad;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_FCS: if (w_last_sym) begin
          r_crc <= {8'h00, r_crc[31:8]};
          if (r_cnt == FCS_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IFG;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_ABORT: if (w_last_sym) begin
          r_cnt   <= '0;
          r_state <= S_IFG;
        end
        S_IFG: if (w_last_sym) begin
          if (r_cnt == IFG_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_eth_tx_gen.sv
// Bench for iob_eth_tx_gen: MII and GMII instances checked each
// cycle against a byte-level frame model.
module tb_iob_eth_tx_gen;

  typedef struct packed {
    logic        en;
    logic        er;
    logic        done;
    logic        rdy;
    logic        achk;
    logic [7:0]  dat;
    logic [10:0] addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        send [2];
  logic [10:0] nb   [2];
  logic        crc  [2];
  logic        pad  [2];
  logic        abrt [2];
  logic [10:0] addr [2];
  logic [7:0]  rd   [2];
  logic        rdy  [2];
  logic        done [2];
  logic        en   [2];
  logic        er   [2];
  logic [3:0]  txd_m;
  logic [7:0]  txd_g;

  logic [7:0]  mem0 [2048];
  logic [7:0]  mem1 [2048];

  exp_t        q0 [$];
  exp_t        q1 [$];
  int          chk = 0;
  int          pass = 0;
  int          en_cnt [2];
  int          done_cnt [2];
  logic [31:0] sreg;
  logic [31:0] last_fcs;

  iob_eth_tx_gen #(.DATA_W(4)) u_mii (
    .tx_clk_i(clk), .rst_i(rst[0]), .addr_o(addr[0]), .data_i(rd[0]),
    .send_i(send[0]), .nbytes_i(nb[0]), .crc_en_i(crc[0]),
    .pad_en_i(pad[0]), .abort_i(abrt[0]), .ready_o(rdy[0]),
    .done_o(done[0]), .tx_en_o(en[0]), .tx_er_o(er[0]),
    .tx_data_o(txd_m)
  );

  iob_eth_tx_gen #(.DATA_W(8)) u_gmii (
    .tx_clk_i(clk), .rst_i(rst[1]), .addr_o(addr[1]), .data_i(rd[1]),
    .send_i(send[1]), .nbytes_i(nb[1]), .crc_en_i(crc[1]),
    .pad_en_i(pad[1]), .abort_i(abrt[1]), .ready_o(rdy[1]),
    .done_o(done[1]), .tx_en_o(en[1]), .tx_er_o(er[1]),
    .tx_data_o(txd_g)
  );

  always @(posedge clk) begin
    rd[0] <= mem0[addr[0]];
    rd[1] <= mem1[addr[1]];
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0]  v);
    logic [31:0] x;
    x = c ^ {24'h0, v};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.rdy  = 1'b1;
    e.achk = 1'b1;
    return e;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] memrd(input int d, input int k);
    return (d == 0) ? mem0[k] : mem1[k];
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Expected wire activity: acceptance cycle, symbols, abort, IFG.
  task automatic build(input int d, input int n, input bit c,
                       input bit p, input int cut, input int ab);
    logic [7:0]  b [$];
    logic [31:0] fcs;
    exp_t        e;
    int          spb;
    int          total;
    int          s;
    bit          hit;
    spb = (d == 0) ? 2 : 1;
    push(d, idle_e());
    for (int i = 0; i < 7; i++) b.push_back(8'h55);
    b.push_back(8'hD5);
    total = (p && n < 60) ? 60 : n;
    fcs = 32'hFFFFFFFF;
    for (int k = 0; k < total; k++) begin
      logic [7:0] v;
      v = (k < n) ? memrd(d, k) : 8'h00;
      b.push_back(v);
      fcs = crc_upd(fcs, v);
    end
    fcs = ~fcs;
    last_fcs = fcs;
    if (c)
      for (int j = 0; j < 4; j++) b.push_back(fcs[8*j +: 8]);
    s = 0;
    hit = 1'b0;
    for (int bi = 0; bi < b.size() && !hit; bi++) begin
      for (int h = 0; h < spb && !hit; h++) begin
        if (cut >= 0 && s > cut) return;
        if (ab >= 0 && s > ab) begin
          hit = 1'b1;
        end else begin
          e = '0;
          e.en = 1'b1;
          if (spb == 2) e.dat = {4'h0, h == 1 ? b[bi][7:4] : b[bi][3:0]};
          else e.dat = b[bi];
          if (d == 1 && bi >= 8 && bi - 8 < n - 1) begin
            e.achk = 1'b1;
            e.addr = 11'(bi - 7);
          end
          push(d, e);
          s++;
        end
      end
    end
    if (hit)
      for (int h = 0; h < spb; h++) begin
        e = '0;
        e.en = 1'b1;
        e.er = 1'b1;
        push(d, e);
      end
    for (int i = 0; i < 12 * spb; i++) begin
      e = '0;
      e.achk = 1'b1;
      e.done = (i == 12 * spb - 1) && !hit;
      push(d, e);
    end
  endtask

  task automatic cmp(input int d);
    exp_t       e;
    logic [7:0] dat;
    bit         ok;
    dat = (d == 0) ? {4'h0, txd_m} : txd_g;
    if (qsize(d) > 0) e = (d == 0) ? q0.pop_front() : q1.pop_front();
    else e = idle_e();
    ok = (en[d] === e.en) && (er[d] === e.er) && (done[d] === e.done) &&
         (rdy[d] === e.rdy) && (dat === e.dat) &&
         (!e.achk || addr[d] === e.addr);
    chk++;
    if (ok) pass++;
    else $display("FAIL cycle dut%0d: en=%b er=%b done=%b rdy=%b d=%h a=%0d expected en=%b er=%b done=%b rdy=%b d=%h a=%0d(%b)",
                  d, en[d], er[d], done[d], rdy[d], dat, addr[d],
                  e.en, e.er, e.done, e.rdy, e.dat, e.addr, e.achk);
    if (en[d] === 1'b1) en_cnt[d]++;
    if (done[d] === 1'b1) done_cnt[d]++;
    if (d == 1 && en[1] === 1'b1) sreg = {sreg[23:0], txd_g};
  endtask

  task automatic tick();
    @(negedge clk);
    cmp(0);
    cmp(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d);
    int g;
    g = 0;
    while (qsize(d) > 0 && g < 3000) begin
      tick();
      g++;
    end
    check("drain", 32'(qsize(d)), 32'd0);
    tick();
  endtask

  task automatic start(input int d, input int n, input bit c,
                       input bit p);
    nb[d]   = 11'(n);
    crc[d]  = c;
    pad[d]  = p;
    send[d] = 1'b1;
  endtask

  task automatic run(input int d, input int n, input bit c,
                     input bit p, input int ab);
    start(d, n, c, p);
    build(d, n, c, p, -1, ab);
    tick();
    send[d] = 1'b0;
    if (ab >= 0) begin
      repeat (ab) tick();
      abrt[d] = 1'b1;
      tick();
      abrt[d] = 1'b0;
    end
    drain(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int dbase;
    int s_a;
    int f3;
    int g;
    for (int k = 0; k < 2048; k++) begin
      mem0[k] = 8'(k * 37 + 5);
      mem1[k] = (k < 9) ? 8'(8'h31 + k) : 8'(k * 29 + 1);
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; send[d] = 1'b0; nb[d] = '0;
      crc[d] = 1'b0; pad[d] = 1'b0; abrt[d] = 1'b0;
      en_cnt[d] = 0; done_cnt[d] = 0;
    end
    sreg = '0;
    last_fcs = '0;
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();
    tick();

    base = en_cnt[0]; dbase = done_cnt[0];
    run(0, 64, 1'b1, 1'b0, -1);
    check("mii64_len", 32'(en_cnt[0] - base), 32'd152);
    check("mii64_done", 32'(done_cnt[0] - dbase), 32'd1);

    base = en_cnt[1];
    run(1, 9, 1'b1, 1'b0, -1);
    check("model_crc", last_fcs, 32'hCBF43926);
    check("gmii9_fcs", sreg, 32'h2639F4CB);
    check("gmii9_len", 32'(en_cnt[1] - base), 32'd21);

    base = en_cnt[0];
    run(0, 14, 1'b1, 1'b1, -1);
    check("mii_pad_len", 32'(en_cnt[0] - base), 32'd144);

    base = en_cnt[1];
    run(1, 20, 1'b0, 1'b0, -1);
    check("gmii20_len", 32'(en_cnt[1] - base), 32'd28);

    base = en_cnt[1];
    run(1, 0, 1'b1, 1'b0, -1);
    check("gmii0_fcs", sreg, 32'h00000000);
    check("gmii0_len", 32'(en_cnt[1] - base), 32'd12);

    base = en_cnt[1];
    run(1, 0, 1'b0, 1'b1, -1);
    check("gmii0_pad_len", 32'(en_cnt[1] - base), 32'd68);

    base = en_cnt[0]; dbase = done_cnt[0];
    run(0, 64, 1'b1, 1'b0, 26);
    check("abort_len", 32'(en_cnt[0] - base), 32'd29);
    check("abort_nodone", 32'(done_cnt[0] - dbase), 32'd0);

    abrt[0] = 1'b1;
    tick();
    abrt[0] = 1'b0;
    dbase = done_cnt[0];
    run(0, 8, 1'b1, 1'b0, -1);
    check("after_abort_done", 32'(done_cnt[0] - dbase), 32'd1);

    // Reset lands in the FCS while send_i stays high throughout.
    base = en_cnt[0];
    start(0, 10, 1'b1, 1'b0);
    build(0, 10, 1'b1, 1'b0, 38, -1);
    tick();
    repeat (38) tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("rst_len", 32'(en_cnt[0] - base), 32'd39);
    build(0, 10, 1'b1, 1'b0, -1, -1);
    s_a = q0.size();
    build(0, 10, 1'b1, 1'b0, -1, -1);
    f3 = q0.size() - s_a;
    g = 0;
    while (q0.size() > f3 - 2 && g < 3000) begin
      tick();
      g++;
    end
    send[0] = 1'b0;
    drain(0);

    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
